// File: rtl/calib_seq_if.sv
// Bus bundle for calib_seq: request/config inputs from the calibration
// command decode and the pulse/LCT/L1A outputs to the drivers.
interface calib_seq_if #(
    parameter int NCH     = 2,
    parameter int DLY_W   = 8,
    parameter int TW      = 12,
    parameter int BURST_W = 8
);
    logic [NCH-1:0]       REQ;
    logic                 ABORT;
    logic [NCH*DLY_W-1:0] CH_DLY;
    logic [3:0]           PLS_WID;
    logic [TW-1:0]        LCT_DLY;
    logic [TW-1:0]        L1A_DLY;
    logic [BURST_W-1:0]   BURST_N;
    logic [BURST_W-1:0]   BURST_GAP;
    logic                 EXT_GTRG;
    logic [NCH-1:0]       PULSE;
    logic                 CALLCT;
    logic                 CAL_GTRG;
    logic                 BUSY;
    logic                 DONE;

    modport master (
        output REQ, ABORT, CH_DLY, PLS_WID, LCT_DLY, L1A_DLY,
               BURST_N, BURST_GAP, EXT_GTRG,
        input  PULSE, CALLCT, CAL_GTRG, BUSY, DONE
    );

    modport slave (
        input  REQ, ABORT, CH_DLY, PLS_WID, LCT_DLY, L1A_DLY,
               BURST_N, BURST_GAP, EXT_GTRG,
        output PULSE, CALLCT, CAL_GTRG, BUSY, DONE
    );
endinterface

// File: rtl/calib_seq.sv
// Calibration trigger sequencer: per-channel pulses, one LCT and one L1A per
// sequence, with bursts. Optional feature macro: CALSEQ_EXT_GTRG_EN.
module calib_seq #(
    parameter int NCH     = 2,
    parameter int DLY_W   = 8,
    parameter int TW      = 12,
    parameter int BURST_W = 8
) (
    input  logic        CLKCMS,
    input  logic        RST,
    calib_seq_if.slave  bus
);
    localparam int MW = (TW > DLY_W) ? TW : DLY_W;
    localparam int CW = ((MW > 4) ? MW : 4) + 1;
    localparam logic [TW-1:0]      T_ONE = TW'(1);
    localparam logic [BURST_W-1:0] B_ONE = BURST_W'(1);
    localparam logic [BURST_W-1:0] B_ZERO = {BURST_W{1'b0}};
    localparam logic [TW-1:0]      T_ZERO = {TW{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

    state_t               state_r, state_s;
    logic [TW-1:0]        t_r, t_s;
    logic [BURST_W-1:0]   bcnt_r, bcnt_s;
    logic [BURST_W-1:0]   gcnt_r, gcnt_s;
    logic                 load_s, run_s, done_s, t_end_s;
    logic [NCH-1:0]       pulse_dec_s;

    logic [NCH-1:0]       mask_r;
    logic [NCH*DLY_W-1:0] ch_dly_r;
    logic [3:0]           pls_wid_r;
    logic [TW-1:0]        lct_dly_r;
    logic [TW-1:0]        l1a_dly_r;
    logic [BURST_W-1:0]   gap_r;

    logic [NCH-1:0]       pulse_r;
    logic                 callct_r, cal_gtrg_r, busy_r, done_r;

    function automatic logic in_window(input logic [TW-1:0]    t,
                                       input logic [DLY_W-1:0] dly,
                                       input logic [3:0]       wid);
        logic [CW-1:0] t_w;
        logic [CW-1:0] lo_w;
        logic [CW-1:0] hi_w;
        t_w  = CW'(t);
        lo_w = CW'(dly);
        hi_w = lo_w + CW'(wid);
        return (t_w >= lo_w) && (t_w <= hi_w);
    endfunction

    assign t_end_s = (t_r == l1a_dly_r);

    // Per-channel pulse window decode against the master timer
    always_comb begin
        pulse_dec_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            pulse_dec_s[i] = mask_r[i] & in_window(t_r, ch_dly_r[i*DLY_W +: DLY_W], pls_wid_r);
        end
    end

    // Next-state, timer and counter logic
    always_comb begin
        state_s = state_r;
        t_s     = t_r;
        bcnt_s  = bcnt_r;
        gcnt_s  = gcnt_r;
        load_s  = 1'b0;
        run_s   = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // A request enters through a zero-length gap so that T=0
                // coincides with the cycle after the request edge.
                if ((bus.REQ != {NCH{1'b0}}) && !bus.ABORT) begin
                    load_s  = 1'b1;
                    state_s = GAP;
                    gcnt_s  = B_ZERO;
                    t_s     = T_ZERO;
                    bcnt_s  = (bus.BURST_N == B_ZERO) ? B_ONE : bus.BURST_N;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (bus.ABORT) begin
                    state_s = IDLE;
                end else begin
                    run_s = 1'b1;
                    if (t_end_s) begin
                        if (bcnt_r == B_ONE) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                            bcnt_s  = B_ZERO;
                        end else begin
                            state_s = GAP;
                            bcnt_s  = bcnt_r - B_ONE;
                            gcnt_s  = gap_r;
                        end
                    end else begin
                        t_s = t_r + T_ONE;
                    end
                end
            end
            GAP: begin
                if (bus.ABORT) begin
                    state_s = IDLE;
                end else if (gcnt_r == B_ZERO) begin
                    state_s = RUN;
                    t_s     = T_ZERO;
                end else begin
                    gcnt_s = gcnt_r - B_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, timer and counters
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            t_r     <= T_ZERO;
            bcnt_r  <= B_ZERO;
            gcnt_r  <= B_ZERO;
        end else begin
            state_r <= state_s;
            t_r     <= t_s;
            bcnt_r  <= bcnt_s;
            gcnt_r  <= gcnt_s;
        end
    end

    // Configuration snapshot taken on an accepted request
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            mask_r    <= {NCH{1'b0}};
            ch_dly_r  <= {(NCH*DLY_W){1'b0}};
            pls_wid_r <= 4'd0;
            lct_dly_r <= T_ZERO;
            l1a_dly_r <= T_ZERO;
            gap_r     <= B_ZERO;
        end else if (load_s) begin
            mask_r    <= bus.REQ;
            ch_dly_r  <= bus.CH_DLY;
            pls_wid_r <= bus.PLS_WID;
            lct_dly_r <= bus.LCT_DLY;
            l1a_dly_r <= bus.L1A_DLY;
            gap_r     <= bus.BURST_GAP;
        end
    end

    // Registered outputs
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            pulse_r    <= {NCH{1'b0}};
            callct_r   <= 1'b0;
            cal_gtrg_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            pulse_r    <= run_s ? pulse_dec_s : {NCH{1'b0}};
            callct_r   <= run_s & (t_r == lct_dly_r);
`ifdef CALSEQ_EXT_GTRG_EN
            cal_gtrg_r <= (run_s & t_end_s) | bus.EXT_GTRG;
`else
            cal_gtrg_r <= run_s & t_end_s;
`endif
            busy_r     <= (state_s != IDLE);
            done_r     <= done_s;
        end
    end

    assign bus.PULSE    = pulse_r;
    assign bus.CALLCT   = callct_r;
    assign bus.CAL_GTRG = cal_gtrg_r;
    assign bus.BUSY     = busy_r;
    assign bus.DONE     = done_r;
endmodule

// File: doc/calib_seq.md
# calib_seq

Parametrised calibration trigger sequencer for the DMB control FPGA. It generates NCH per-channel calibration pulses, one calibration LCT, and one calibration L1A from a single request, with programmable per-channel offsets and a programmable pulse width. It supports bursts of repeated sequences with a programmable gap between them. It sits between the CCB/JTAG calibration command decode and the CFEB/ALCT pulse drivers.

## Interface
Parameters:
- NCH, 2, number of pulse channels (1..8)
- DLY_W, 8, width of each per-channel delay field
- TW, 12, width of the master timer and of LCT_DLY/L1A_DLY
- BURST_W, 8, width of burst count and gap fields

Ports:
- CLKCMS  in  1  system clock (40 MHz)
- RST  in  1  asynchronous, active-high reset
- REQ  in  NCH  channel request mask; nonzero for one cycle starts a sequence
- ABORT  in  1  synchronous abort
- CH_DLY  in  NCH*DLY_W  per-channel pulse offset; channel i occupies bits [i*DLY_W +: DLY_W]
- PLS_WID  in  4  pulse width minus 1
- LCT_DLY  in  TW  LCT offset
- L1A_DLY  in  TW  L1A offset; also sets the sequence length
- BURST_N  in  BURST_W  sequences per request (0 is treated as 1)
- BURST_GAP  in  BURST_W  idle cycles between sequences, minus 1
- EXT_GTRG  in  1  external/random L1A request (used only with CALSEQ_EXT_GTRG_EN)
- PULSE  out  NCH  calibration pulses, registered
- CALLCT  out  1  calibration LCT, 1-cycle pulse, registered
- CAL_GTRG  out  1  calibration L1A, 1-cycle pulse, registered
- BUSY  out  1  sequence in progress
- DONE  out  1  1-cycle pulse on normal completion

## Operation
- States: IDLE, RUN, GAP.
- IDLE: when REQ != 0, the block latches REQ (mask), CH_DLY, PLS_WID, LCT_DLY, L1A_DLY, BURST_N, and BURST_GAP. It then sets T=0 and the burst counter to max(BURST_N,1), and moves to RUN. REQ is ignored outside IDLE.
- RUN: T increments every cycle.
  - Output decodes, computed in TW+1 bits so there is no overflow:
    - PULSE[i] = mask[i] & (T >= CH_DLY_i) & (T <= CH_DLY_i + PLS_WID)
    - CALLCT = (T == LCT_DLY)
    - CAL_GTRG = (T == L1A_DLY)
  - When T == L1A_DLY: decrement the burst counter. If the counter was 1, go to IDLE and assert DONE. Otherwise go to GAP and load the gap counter with BURST_GAP.
  - Any pulse or LCT whose offset exceeds L1A_DLY is truncated or never fires. This is intended.
- GAP: all outputs are low. The gap counter decrements each cycle. At 0, T is set to 0 and the state returns to RUN with the same latched configuration.
- ABORT in RUN or GAP: go to IDLE on the next edge. PULSE, CALLCT, and CAL_GTRG are low from the next edge onward. DONE is not asserted. ABORT has priority over completion in the same cycle. ABORT in IDLE has no effect, and a simultaneous REQ is ignored.
- BUSY = (state != IDLE), registered with the state.
- Configuration inputs that change during BUSY have no effect until the next request.
- RST: state IDLE; T, counters, and latched configuration cleared; PULSE=0, CALLCT=0, CAL_GTRG=0, BUSY=0, DONE=0. An RST during RUN or GAP truncates any pulse in progress immediately (asynchronous).

## Timing
- Edge e0 samples REQ. BUSY is high from e0 onward.
- PULSE[i] rises at edge e0+CH_DLY_i+2 and stays high for PLS_WID+1 cycles.
- CALLCT is high for the one cycle starting at edge e0+LCT_DLY+2.
- CAL_GTRG is high for the one cycle starting at edge e0+L1A_DLY+2.
- One sequence spans L1A_DLY+1 RUN cycles.
- In a burst, sequence k+1 starts (T=0) BURST_GAP+1 cycles after sequence k ends. The burst period is L1A_DLY+BURST_GAP+2 cycles.
- DONE is high for one cycle at the edge where state returns to IDLE. BUSY falls on that same edge.
- A new REQ is accepted on the first edge where BUSY=0, including the cycle in which DONE is high.

## Configuration
- CALSEQ_EXT_GTRG_EN defined:
  - CAL_GTRG = registered (internal L1A decode | EXT_GTRG), active in any state.
  - EXT_GTRG has one cycle of latency and does not affect BUSY or DONE.
- CALSEQ_EXT_GTRG_EN undefined: EXT_GTRG is unused and CAL_GTRG comes only from the sequencer.

## Test plan
- Single sequence: NCH=2, REQ=2'b11, CH_DLY={8'd5,8'd3}, PLS_WID=1, LCT_DLY=10, L1A_DLY=20, BURST_N=1 -> PULSE[0] high at e0+5..6, PULSE[1] high at e0+7..8, CALLCT at e0+12, CAL_GTRG at e0+22, DONE at e0+22, BUSY low after.
- Burst: REQ=2'b01, BURST_N=3, BURST_GAP=4, L1A_DLY=10 -> exactly 3 CAL_GTRG pulses spaced 16 cycles apart, DONE once, with the third CAL_GTRG on the DONE edge.
- Mask and truncation: REQ=2'b10, CH_DLY[1]=30, L1A_DLY=20 -> PULSE all zero for the whole sequence, CAL_GTRG still fires.
- Abort: ABORT at e0+8 during the earlier single-sequence config -> all outputs low from e0+9, no CALLCT/CAL_GTRG/DONE, a new REQ at e0+9 is accepted.
- Reset mid-pulse: RST asserted while PULSE[0]=1 -> PULSE/BUSY drop immediately; after release, the block idles until the next REQ.
- CALSEQ_EXT_GTRG_EN defined, EXT_GTRG pulse in IDLE -> CAL_GTRG high 1 cycle later, BUSY stays 0; undefined -> CAL_GTRG stays 0.
